// File: rtl/mm3_pkg.sv
// mm3_pkg: shared state encoding, sizes and indexing helper for the 3x3 sequencer
package mm3_pkg;
  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} mm3_state_e;
  localparam int MM3_N = 3;
  localparam int MM3_ELEMS = 9;
  localparam int MM3_ACC_W = 18;
  function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
    return 4'(r) * 4'(MM3_N) + 4'(c);
  endfunction
endpackage

// File: rtl/mm3_mac.sv
// mm3_mac: 8x8 unsigned multiply feeding an 18-bit registered accumulator
module mm3_mac
  import mm3_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [7:0]           a,
  input  logic [7:0]           b,
  output logic [MM3_ACC_W-1:0] acc
);
  logic [15:0] prod;
  assign prod = a * b;
  // load starts a fresh dot product, otherwise the product is added on
  always_ff @(posedge clk)
    if (rst) acc <= '0;
    else if (en) acc <= load ? MM3_ACC_W'(prod) : acc + MM3_ACC_W'(prod);
endmodule

// File: rtl/mm3_seq_ctrl.sv
// mm3_seq_ctrl: walks 27 products through one shared MAC into the C bank
module mm3_seq_ctrl
  import mm3_pkg::*;
#(
  parameter int MAT_N = 3,
  parameter int DAT_W = 8,
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [3:0]       wr_addr,
  input  logic [DAT_W-1:0] wr_data,
  input  logic [3:0]       rd_addr,
  output logic [RES_W-1:0] rd_data,
  output logic             ovf
);
  mm3_state_e state, state_d;
  logic [1:0] i, j, k;
  logic [DAT_W-1:0] a_bank [MM3_ELEMS];
  logic [DAT_W-1:0] b_bank [MM3_ELEMS];
  logic [RES_W-1:0] c_bank [MM3_ELEMS];
  logic [MM3_ACC_W-1:0] acc;
  logic k_last, j_last, elem_last, idle;
  assign idle = state == IDLE;
  assign k_last = k == 2'(MAT_N - 1);
  assign j_last = j == 2'(MAT_N - 1);
  assign elem_last = j_last && i == 2'(MAT_N - 1);
  assign busy = state == MAC || state == STORE;
  assign done = state == DONE;
  mm3_mac u_mac (
    .clk (clk),
    .rst (rst),
    .load(k == 2'd0),
    .en  (state == MAC),
    .a   (a_bank[idx(i, k)]),
    .b   (b_bank[idx(k, j)]),
    .acc (acc)
  );
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_d;
  // next-state: three MAC cycles then one STORE per element, DONE after the ninth
  always_comb begin
    state_d = state;
    state_d = idle ? (start ? MAC : IDLE) :
              state == MAC ? (k_last ? STORE : MAC) :
              state == STORE ? (elem_last ? DONE : MAC) : IDLE;
  end
  // i/j/k walk in row-major order; ovf clears on an accepted start and is sticky afterwards
  always_ff @(posedge clk)
    if (rst || (idle && start)) begin
      i <= '0;
      j <= '0;
      k <= '0;
      ovf <= 1'b0;
    end else if (state == MAC) k <= k_last ? 2'd0 : k + 2'd1;
    else if (state == STORE) begin
      j <= j_last ? 2'd0 : j + 2'd1;
      i <= j_last ? (i == 2'(MAT_N - 1) ? 2'd0 : i + 2'd1) : i;
      ovf <= ovf | (|acc[MM3_ACC_W-1:RES_W]);
    end
  // operand writes only while idle, C written on STORE, C read back every cycle
  always_ff @(posedge clk)
    if (rst) begin
      for (int n = 0; n < MM3_ELEMS; n++) begin
        a_bank[n] <= '0;
        b_bank[n] <= '0;
        c_bank[n] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (idle && wr_en && wr_addr < 4'(MM3_ELEMS)) begin
        if (wr_sel) b_bank[wr_addr] <= wr_data;
        else a_bank[wr_addr] <= wr_data;
      end
      if (state == STORE) c_bank[idx(i, j)] <= acc[RES_W-1:0];
      rd_data <= rd_addr < 4'(MM3_ELEMS) ? c_bank[rd_addr] : '0;
    end
endmodule

// File: doc/mm3_seq_ctrl.md
# mm3_seq_ctrl

Sequencing controller for the 3x3 matrix-multiply accelerator. Owns the A/B operand register banks (written over a simple byte-wide port) and a single shared 8x8 multiply-accumulate unit. On `start`, it walks the 27 products in row-major order and writes the nine 16-bit results into a C bank readable by the host. A `start`/`busy`/`done` handshake replaces the free-running, fully-parallel matrix datapath, trading 36 cycles of latency for one multiplier.

## Interface
- `MAT_N`, 3, matrix dimension (fixed at 3; other values not supported)
- `DAT_W`, 8, operand width (unsigned)
- `RES_W`, 16, stored result width
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  request computation; sampled only in IDLE
- `busy`  out  1  high while computing
- `done`  out  1  one-cycle pulse when C is complete
- `wr_en`  in  1  operand write strobe
- `wr_sel`  in  1  0 = A bank, 1 = B bank
- `wr_addr`  in  4  element index, row-major (r*3+c), valid range 0..8
- `wr_data`  in  8  operand value
- `rd_addr`  in  4  C element index 0..8
- `rd_data`  out  16  registered C element
- `ovf`  out  1  sticky: some dot product exceeded 16 bits in the last run

## Operation
- Reset values:
  - `busy`, `done`, `ovf` = 0; `rd_data` = 0.
  - A, B and C banks all zero.
  - FSM in IDLE.
- FSM states: IDLE, MAC, STORE, DONE.
  - IDLE -> MAC on `start`. On that edge, clear `ovf` and set i = j = k = 0.
  - MAC: accumulate A[i*3+k]*B[k*3+j]. At k = 0 the accumulator is loaded rather than added to. k increments each cycle; after k = 2, go to STORE.
  - STORE: C[i*3+j] <= acc[15:0]. If acc > 65535, set `ovf`. Advance j, then i (row-major). After element 8, go to DONE; otherwise go to MAC with k = 0.
  - DONE: `done` = 1 for one cycle, then IDLE.
- Arithmetic:
  - Products are 16-bit unsigned.
  - The accumulator is 18 bits (max 3*255*255 = 195075, no internal overflow).
  - Stored result is truncated to the low 16 bits.
- Writes:
  - Accepted only when FSM is IDLE; ignored during MAC/STORE/DONE.
  - Writes with `wr_addr` > 8 are ignored.
  - `wr_en` and `start` in the same IDLE cycle: the write lands and is used by the run.
- Reads:
  - `rd_data` <= C[rd_addr] every cycle, including while busy; an in-progress C may be partially updated.
  - `rd_addr` > 8 returns 0.
- `start` while not IDLE is ignored (no queuing).
- `rst` asserted mid-run:
  - Next cycle is IDLE with all outputs at reset values.
  - Banks are cleared; no `done` is produced.

## Timing
- Edge 0 samples `start`; the first cycle after edge 0 is cycle 1.
- Element e occupies:
  - MAC in cycles 4e+1..4e+3;
  - STORE in cycle 4e+4.
- `busy` is high in cycles 1..36.
- `done` is high in cycle 37, with `busy` = 0. A new `start` is accepted from cycle 38 (first IDLE cycle).
- Back-to-back runs have a period of 38 cycles minimum.
- `rd_data` has 1-cycle latency from `rd_addr`. C[e] is visible in `rd_data` from cycle 4e+6 if addressed.
- `ovf` is valid from the cycle after the STORE that sets it and holds until the next accepted `start` or `rst`.

## Structure
- Package `mm3_pkg`:
  - FSM state enum `mm3_state_e`;
  - constants `MM3_N = 3`, `MM3_ELEMS = 9`, `MM3_ACC_W = 18`.
- Sub-module `mm3_mac`:
  - 8x8 unsigned multiply with 18-bit accumulator;
  - inputs `load`/`en`, registered `acc` output.
- The controller holds the FSM, i/j/k counters, the three register banks and the read mux.

## Test plan
- A = identity, B = 1..9, start at edge 0 -> `done` in cycle 37 only; C reads 1..9; `ovf` = 0; `busy` high in cycles 1..36.
- A = B = all 255 -> every C = 64003 (195075 mod 65536); `ovf` = 1; a following run with A = 0 clears `ovf` at start and leaves it 0.
- A = 1..9, B = 9..1 -> C = {30,24,18,84,69,54,138,114,90}; `start` pulsed again in cycle 10 is ignored; exactly one `done`.
- `rst` in cycle 20 of a run -> next cycle `busy` = 0, no `done`, all C reads return 0, and a subsequent full run completes normally.
- Writes to address 9..15 and writes during `busy` -> banks unchanged; reads of `rd_addr` 12 return 0.
- `wr_en` (A[0] = 7) coincident with `start`, rest of A = 0, B = identity -> C[0..2] = {7,0,0}, remaining elements 0.
